// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Brief    : PC owner and fetch sequencer for a 1-cycle-latency instruction
//            memory, with a 2-entry output buffer, redirect and halt/drain.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    input  logic        halt_req,
    output logic        halted
);

    localparam logic [2:0]  c_credit = 3'(FIFO_DEPTH);
    localparam logic [31:0] c_step   = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_rsp_pc;
    logic        r_inflight;
    logic [1:0]  r_count;
    logic [31:0] r_pc0, r_ins0, r_pc1, r_ins1;
    logic        r_misalign;

    logic [31:0] w_target;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_issue;

    assign w_target = {redirect_pc[31:2], 2'b00};
    assign w_pop    = out_valid & out_ready & ~redirect_valid;
    assign w_push   = r_inflight & ~redirect_valid;

    // A redirect empties the buffer and kills the response, so it frees all credit.
    assign w_occ    = redirect_valid ? 3'd0
                    : ({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop});
    assign w_issue  = (r_state == ST_RUN) && (w_occ < c_credit);

    assign imem_req     = w_issue & ~reset;
    assign imem_addr    = redirect_valid ? w_target : r_pc;
    assign out_valid    = (r_count != 2'd0);
    assign out_pc       = r_pc0;
    assign out_instr    = r_ins0;
    assign misalign_err = r_misalign;
    assign halted       = (r_state == ST_HALTED);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (halt_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!halt_req)        w_state_nxt = ST_RUN;
                else if (!r_inflight) w_state_nxt = ST_HALTED;
            end
            ST_HALTED: if (!halt_req) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_rsp_pc   <= '0;
            r_inflight <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_misalign <= redirect_valid & (|redirect_pc[1:0]);
            if (w_issue) begin
                r_pc     <= imem_addr + c_step;
                r_rsp_pc <= imem_addr;
            end else if (redirect_valid) begin
                r_pc     <= w_target;
            end
        end
    end

    // Two-entry shift buffer; entry 0 is always the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_pc0   <= '0;
            r_ins0  <= '0;
            r_pc1   <= '0;
            r_ins1  <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_pc0  <= r_pc1;
                        r_ins0 <= r_ins1;
                        r_pc1  <= r_rsp_pc;
                        r_ins1 <= imem_rdata;
                    end else begin
                        r_pc0  <= r_rsp_pc;
                        r_ins0 <= imem_rdata;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0  <= r_rsp_pc;
                        r_ins0 <= imem_rdata;
                    end else begin
                        r_pc1  <= r_rsp_pc;
                        r_ins1 <= imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0   <= r_pc1;
                    r_ins0  <= r_ins1;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
